// File: rtl/colocador_bombas.sv
// colocador_bombas: places up to MAX_BOMBAS distinct bombs on an 8x8 board using an LFSR, never on the safe cell
// Ports: clk, rst (async, active-low), start, num_bombas, safe_cell in;
//        bomb_mask (bit i = cell row*8+col), bomb_count, busy, done, valid, error out.
module colocador_bombas #(
    parameter logic [7:0] SEED       = 8'hA5,
    parameter logic [5:0] MAX_BOMBAS = 6'd16,
    parameter logic [9:0] TIMEOUT    = 10'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  num_bombas,
    input  logic [5:0]  safe_cell,
    output logic [63:0] bomb_mask,
    output logic [5:0]  bomb_count,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        error
);
    typedef enum logic [1:0] {IDLE, LOAD, PLACE, DONE} state_t;
    // An all-zero seed would lock the LFSR up
    localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [5:0]  target_q, target_d;
    logic [5:0]  safe_q, safe_d;
    logic [63:0] mask_q, mask_d;
    logic [5:0]  count_q, count_d;
    logic [9:0]  cyc_q, cyc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [5:0]  cand;
    logic        accept;

    always_comb begin
        // x^8+x^6+x^5+x^4+1; runs in every state so start timing varies the pattern
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand     = lfsr_q[5:0];
        accept   = (state_q == PLACE) && (cand != safe_q) && !mask_q[cand];
        state_d  = state_q;
        target_d = target_q;
        safe_d   = safe_q;
        mask_d   = mask_q;
        count_d  = count_q;
        cyc_d    = cyc_q;
        valid_d  = valid_q;
        error_d  = error_q;
        case (state_q)
            IDLE: if (start) begin
                target_d = (num_bombas > MAX_BOMBAS) ? MAX_BOMBAS : num_bombas;
                safe_d   = safe_cell;
                valid_d  = 1'b0;
                error_d  = 1'b0;
                state_d  = LOAD;
            end
            LOAD: begin
                mask_d  = '0;
                count_d = '0;
                cyc_d   = '0;
                state_d = (target_q == 6'd0) ? DONE : PLACE;
            end
            PLACE: begin
                cyc_d = cyc_q + 10'd1;
                if (accept) begin
                    mask_d[cand] = 1'b1;
                    count_d      = count_q + 6'd1;
                end
                // Reaching the target on the last allowed cycle counts as success
                if (accept && (count_q + 6'd1 == target_q)) begin
                    state_d = DONE;
                end else if (cyc_q + 10'd1 == TIMEOUT) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = !error_q;
                state_d = IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with it
        busy_d = (state_d == LOAD) || (state_d == PLACE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_INIT;
            target_q <= '0;
            safe_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            cyc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            safe_q   <= safe_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bomb_mask  = mask_q;
    assign bomb_count = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign error      = error_q;
endmodule
